// File: rtl/bomb_flame.sv
// bomb_flame
//   Explosion propagation stage. A rising edge on detonate latches the bomb
//   tile. The block then probes the tile map outward right, left, down and up,
//   one tile per cycle and up to RANGE tiles in each direction. It holds the
//   flame pattern for FLAME_FRAMES cycles and then pulses flame_done.
//
// Ports
//   frame_clk            sole clock
//   Reset                synchronous, active-low reset
//   detonate             level; rising edge starts an explosion (IDLE only)
//   bomb_x/bomb_y        bomb tile, sampled on the detonate edge
//   query_x/query_y      tile being probed (0 when no in-grid probe)
//   query_valid          probe is in-grid (SCAN only)
//   query_solid/brick    combinational map answer for the probed tile
//   flame_x/flame_y      latched centre tile
//   ext_right..ext_up    flame extent per direction, 0..RANGE
//   flame_active         flame pattern valid (HOLD)
//   brick_clear          one-cycle pulse, clear brick at brick_x/brick_y
//   flame_done           one-cycle pulse at end of explosion
//   busy                 state != IDLE
//   state_dbg            current FSM state, for observation
//
// Handshake: there is no backpressure. A start is the cycle where detonate is
// high and was low on the previous cycle. It is accepted only in IDLE and is
// dropped in every other state. brick_clear and flame_done are fire-and-forget
// single-cycle strobes.
module bomb_flame #(
    parameter int RANGE        = 2,
    parameter int FLAME_FRAMES = 30,
    parameter int GRID_W       = 15,
    parameter int GRID_H       = 13
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       detonate,
    input  logic [3:0] bomb_x,
    input  logic [3:0] bomb_y,
    output logic [3:0] query_x,
    output logic [3:0] query_y,
    output logic       query_valid,
    input  logic       query_solid,
    input  logic       query_brick,
    output logic [3:0] flame_x,
    output logic [3:0] flame_y,
    output logic [1:0] ext_right,
    output logic [1:0] ext_left,
    output logic [1:0] ext_down,
    output logic [1:0] ext_up,
    output logic       flame_active,
    output logic       brick_clear,
    output logic [3:0] brick_x,
    output logic [3:0] brick_y,
    output logic       flame_done,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;
    typedef enum logic [1:0] {RIGHT, LEFT, DOWN, UP} dir_t;

    localparam int             CW       = $clog2(FLAME_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FLAME_FRAMES - 1);
    localparam logic [1:0]     STEP_MAX = 2'(RANGE);
    localparam logic [5:0]     GW       = 6'(GRID_W);
    localparam logic [5:0]     GH       = 6'(GRID_H);

    state_t        state, state_n;
    dir_t          dir, dir_n;
    logic [1:0]    step, step_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          det_q;

    logic          start;
    logic          in_grid;
    logic          advance;
    logic [1:0]    ext_val;
    // Probe coordinates are kept wider than the tile coordinates. A step left
    // of column 0 wraps and sets bit 5. A step right of column 15 cannot reach
    // bit 5. So a set top bit always means the probe is off the grid.
    logic [5:0]    px, py;

    assign flame_active = (state == HOLD);
    assign flame_done   = (state == DONE);
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    always_comb begin
        start       = detonate & ~det_q;
        px          = {2'b00, flame_x};
        py          = {2'b00, flame_y};
        advance     = 1'b0;
        ext_val     = 2'd0;
        state_n     = state;
        dir_n       = dir;
        step_n      = step;
        cnt_n       = cnt;
        query_valid = 1'b0;
        query_x     = 4'd0;
        query_y     = 4'd0;
        brick_clear = 1'b0;
        brick_x     = 4'd0;
        brick_y     = 4'd0;

        case (dir)
            RIGHT:   px = px + {4'b0000, step};
            LEFT:    px = px - {4'b0000, step};
            DOWN:    py = py + {4'b0000, step};
            default: py = py - {4'b0000, step};
        endcase
        in_grid = ~px[5] && ~py[5] && (px < GW) && (py < GH);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SCAN;
                    dir_n   = RIGHT;
                    step_n  = 2'd1;
                end
            end
            SCAN: begin
                if (!in_grid) begin
                    ext_val = step - 2'd1;
                    advance = 1'b1;
                end else begin
                    query_valid = 1'b1;
                    query_x     = px[3:0];
                    query_y     = py[3:0];
                    // A wall wins over a brick when the map reports both.
                    if (query_solid) begin
                        ext_val = step - 2'd1;
                        advance = 1'b1;
                    end else if (query_brick) begin
                        ext_val     = step;
                        advance     = 1'b1;
                        brick_clear = 1'b1;
                        brick_x     = px[3:0];
                        brick_y     = py[3:0];
                    end else begin
                        ext_val = step;
                        advance = (step == STEP_MAX);
                    end
                end
                if (advance) begin
                    step_n = 2'd1;
                    if (dir == UP) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        dir_n = dir_t'(dir + 2'd1);
                    end
                end else begin
                    step_n = step + 2'd1;
                end
            end
            HOLD: begin
                if (cnt == CNT_LAST) state_n = DONE;
                else                 cnt_n   = cnt + CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state     <= IDLE;
            dir       <= RIGHT;
            step      <= 2'd0;
            cnt       <= '0;
            det_q     <= 1'b0;
            flame_x   <= 4'd0;
            flame_y   <= 4'd0;
            ext_right <= 2'd0;
            ext_left  <= 2'd0;
            ext_down  <= 2'd0;
            ext_up    <= 2'd0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            step  <= step_n;
            cnt   <= cnt_n;
            det_q <= detonate;
            if (state == IDLE && start) begin
                flame_x   <= bomb_x;
                flame_y   <= bomb_y;
                ext_right <= 2'd0;
                ext_left  <= 2'd0;
                ext_down  <= 2'd0;
                ext_up    <= 2'd0;
            end
            // Every probe rewrites its direction's extent. The last probe in
            // each direction leaves the final value.
            if (state == SCAN) begin
                case (dir)
                    RIGHT:   ext_right <= ext_val;
                    LEFT:    ext_left  <= ext_val;
                    DOWN:    ext_down  <= ext_val;
                    default: ext_up    <= ext_val;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bomb_flame.sv
module tb_bomb_flame;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       detonate;
    logic [3:0] bomb_x, bomb_y;
    logic [3:0] query_x, query_y;
    logic       query_valid, query_solid, query_brick;
    logic [3:0] flame_x, flame_y;
    logic [1:0] ext_right, ext_left, ext_down, ext_up;
    logic       flame_active, brick_clear, flame_done, busy;
    logic [3:0] brick_x, brick_y;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Record layout: [35:32] out-of-grid probes, [31:28] scan cycles,
    // [27:20] extents r,l,d,u, [19:12] centre x,y, [11:8] brick pulses,
    // [7:0] last brick x,y
    logic [35:0] exp_q[$];

    logic solid_map [15][13];
    logic brick_map [15][13];

    bomb_flame dut (
        .frame_clk(frame_clk), .Reset(Reset), .detonate(detonate),
        .bomb_x(bomb_x), .bomb_y(bomb_y),
        .query_x(query_x), .query_y(query_y), .query_valid(query_valid),
        .query_solid(query_solid), .query_brick(query_brick),
        .flame_x(flame_x), .flame_y(flame_y),
        .ext_right(ext_right), .ext_left(ext_left),
        .ext_down(ext_down), .ext_up(ext_up),
        .flame_active(flame_active), .brick_clear(brick_clear),
        .brick_x(brick_x), .brick_y(brick_y),
        .flame_done(flame_done), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 frame_clk = ~frame_clk;

    // Tile map answers combinationally for the probed tile
    always_comb begin
        query_solid = 1'b0;
        query_brick = 1'b0;
        if (query_valid && query_x < 4'd15 && query_y < 4'd13) begin
            query_solid = solid_map[query_x][query_y];
            query_brick = brick_map[query_x][query_y];
        end
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input int inv, input int scan,
                                       input int r, input int l, input int d, input int u,
                                       input int cx, input int cy, input int nb,
                                       input int bx, input int by);
        mk = {4'(inv), 4'(scan), 2'(r), 2'(l), 2'(d), 2'(u),
              4'(cx), 4'(cy), 4'(nb), 4'(bx), 4'(by)};
    endfunction

    task automatic clear_map();
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 13; j++) begin
                solid_map[i][j] = 1'b0;
                brick_map[i][j] = 1'b0;
            end
    endtask

    // Driver: present a rising detonate edge with the bomb tile
    task automatic fire(input logic [3:0] bx, input logic [3:0] by);
        @(negedge frame_clk);
        bomb_x   = bx;
        bomb_y   = by;
        detonate = 1'b1;
    endtask

    // Observe one explosion up to flame_done, then compare with the queue head
    task automatic watch(input bit hold, input bit glitch);
        int          scan = 0, inv = 0, nb = 0, act = 0, cyc = 0;
        logic [7:0]  bc = 8'd0;
        bit          done = 1'b0;
        logic [35:0] obs, e;
        while (!done && cyc < 300) begin
            @(negedge frame_clk);
            cyc++;
            if (cyc == 1) begin
                bomb_x = 4'hd;
                bomb_y = 4'h2;
                if (!hold) detonate = 1'b0;
            end
            if (state_dbg == 2'd1) scan++;
            if (state_dbg == 2'd1 && !query_valid) inv++;
            if (brick_clear) begin
                nb++;
                bc = {brick_x, brick_y};
            end
            if (flame_active) act++;
            if (glitch && act == 5) detonate = 1'b1;
            if (glitch && act == 8) detonate = 1'b0;
            if (flame_done) done = 1'b1;
        end
        chk("flame_done_seen", 36'(done), 36'd1);
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        obs = {4'(inv), 4'(scan), ext_right, ext_left, ext_down, ext_up,
               flame_x, flame_y, 4'(nb), bc};
        chk("active_cycles", 36'(act), 36'd30);
        chk("probe_invalid", 36'(obs[35:32]), 36'(e[35:32]));
        chk("scan_cycles",   36'(obs[31:28]), 36'(e[31:28]));
        chk("extents",       36'(obs[27:20]), 36'(e[27:20]));
        chk("centre",        36'(obs[19:12]), 36'(e[19:12]));
        chk("brick_pulses",  36'(obs[11:8]),  36'(e[11:8]));
        chk("brick_coord",   36'(obs[7:0]),   36'(e[7:0]));
        @(negedge frame_clk);
        chk("idle_after_done", 36'({busy, flame_done, flame_active}), 36'd0);
        chk("extents_kept", 36'({ext_right, ext_left, ext_down, ext_up}), 36'(e[27:20]));
    endtask

    // Count busy cycles and flame_done pulses over a window
    task automatic quiet(input int n, output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge frame_clk);
            if (busy) nbusy++;
            if (flame_done) ndone++;
        end
    endtask

    initial begin
        int nbusy, ndone, act;
        clear_map();
        Reset    = 1'b0;
        detonate = 1'b0;
        bomb_x   = 4'd0;
        bomb_y   = 4'd0;
        repeat (3) @(negedge frame_clk);
        chk("reset_outs_a", 36'({query_x, query_y, query_valid, flame_x, flame_y,
                                 ext_right, ext_left, ext_down, ext_up}), 36'd0);
        chk("reset_outs_b", 36'({flame_active, brick_clear, brick_x, brick_y,
                                 flame_done, busy, state_dbg}), 36'd0);
        Reset = 1'b1;
        @(negedge frame_clk);

        // Open field
        exp_q.push_back(mk(0, 8, 2, 2, 2, 2, 7, 6, 0, 0, 0));
        fire(4'd7, 4'd6);
        watch(1'b0, 1'b0);

        // Solid to the right, brick to the left
        solid_map[8][6] = 1'b1;
        brick_map[6][6] = 1'b1;
        exp_q.push_back(mk(0, 6, 0, 1, 2, 2, 7, 6, 1, 6, 6));
        fire(4'd7, 4'd6);
        watch(1'b0, 1'b0);

        // Corner bomb
        clear_map();
        exp_q.push_back(mk(2, 6, 2, 0, 2, 0, 0, 0, 0, 0, 0));
        fire(4'd0, 4'd0);
        watch(1'b0, 1'b0);

        // Solid and brick on the same tile above
        solid_map[7][5] = 1'b1;
        brick_map[7][5] = 1'b1;
        exp_q.push_back(mk(0, 7, 2, 2, 2, 0, 7, 6, 0, 0, 0));
        fire(4'd7, 4'd6);
        watch(1'b0, 1'b0);

        // Far edge: bomb at (14,12), right and down leave the grid at once
        clear_map();
        exp_q.push_back(mk(2, 6, 0, 2, 0, 2, 14, 12, 0, 0, 0));
        fire(4'd14, 4'd12);
        watch(1'b0, 1'b0);

        // Detonate held high: one explosion only, then a fresh edge gives a second
        exp_q.push_back(mk(0, 8, 2, 2, 2, 2, 7, 6, 0, 0, 0));
        fire(4'd7, 4'd6);
        watch(1'b1, 1'b0);
        quiet(150, nbusy, ndone);
        chk("held_no_rearm", 36'({16'(nbusy), 16'(ndone)}), 36'd0);
        detonate = 1'b0;
        @(negedge frame_clk);
        exp_q.push_back(mk(0, 8, 2, 2, 2, 2, 3, 4, 0, 0, 0));
        fire(4'd3, 4'd4);
        watch(1'b0, 1'b0);

        // Rising edge during HOLD is ignored
        exp_q.push_back(mk(0, 8, 2, 2, 2, 2, 5, 5, 0, 0, 0));
        fire(4'd5, 4'd5);
        watch(1'b0, 1'b1);
        quiet(60, nbusy, ndone);
        chk("hold_edge_ignored", 36'({16'(nbusy), 16'(ndone)}), 36'd0);

        // Reset pulse in the middle of HOLD
        fire(4'd7, 4'd6);
        act = 0;
        for (int i = 0; i < 100 && act < 10; i++) begin
            @(negedge frame_clk);
            detonate = 1'b0;
            if (flame_active) act++;
        end
        chk("reached_hold", 36'(act), 36'd10);
        Reset = 1'b0;
        @(negedge frame_clk);
        Reset = 1'b1;
        chk("midhold_reset_a", 36'({query_x, query_y, query_valid, flame_x, flame_y,
                                    ext_right, ext_left, ext_down, ext_up}), 36'd0);
        chk("midhold_reset_b", 36'({flame_active, brick_clear, brick_x, brick_y,
                                    flame_done, busy, state_dbg}), 36'd0);
        quiet(60, nbusy, ndone);
        chk("no_done_after_reset", 36'({16'(nbusy), 16'(ndone)}), 36'd0);

        chk("queue_drained", 36'(exp_q.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
